vga_scan_timing: RTL
====================

// Module: vga_scan_timing
// PURPOSE
//  Upstream raster stage: generates 640x480@60 VGA timing and the pixel coordinates x/y consumed by
//  text_layer and the sprite/HUD layers. Divides the system clock to a pixel-rate enable and runs
//  horizontal/vertical counters. Emits sync, video_on and per-line/per-frame strobes for game logic.
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch (pixels)
//  H_SYNC      96   hsync pulse width (pixels)
//  H_BACK      48   horizontal back porch (pixels)
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BACK      33   vertical back porch (lines)
//  CLK_DIV     2    system clocks per pixel (>=1); 50 MHz -> 25 MHz pixel rate
//  SYNC_ACTIVE 0    sync pulse level (0 = active-low, VGA standard)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  x            out  10  horizontal count 0..H_TOTAL-1 (H_TOTAL=800)
//  y            out  10  vertical count 0..V_TOTAL-1 (V_TOTAL=525)
//  hsync        out  1   horizontal sync, level SYNC_ACTIVE during pulse
//  vsync        out  1   vertical sync, level SYNC_ACTIVE during pulse
//  video_on     out  1   1 when x<H_VISIBLE && y<V_VISIBLE
//  pixel_tick   out  1   1-clk pulse; counters advance on this cycle
//  line_start   out  1   1-clk pulse when x wraps to 0
//  frame_start  out  1   1-clk pulse when (x,y) wraps to (0,0)
// BEHAVIOUR
//  - Clock/reset: single clock clk; reset is synchronous, active-high; all state changes on posedge clk.
//  - Reset values: div=0, x=0, y=0, hsync=vsync=!SYNC_ACTIVE, video_on=0, all pulses 0.
//  - Divider: div counts 0..CLK_DIV-1; pixel_tick=1 in the cycle div==CLK_DIV-1. CLK_DIV==1: tick every cycle.
//  - On pixel_tick: x<=x+1; at x==H_TOTAL-1, x<=0 and y<=y+1; at y==V_TOTAL-1 with x wrap, y<=0.
//  - All outputs registered, decoded from the next counter values, so they align with x/y on the same cycle.
//  - hsync active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//  - vsync active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
//  - video_on=0 during reset; 1 from the first clk after reset release (counters at 0,0).
//  - line_start/frame_start assert only in a pixel_tick cycle; frame_start implies line_start.
//  - Reset mid-frame: next edge forces reset values; raster restarts from (0,0), no partial-line resume.
//  - H_TOTAL and V_TOTAL must be <=1024 (10-bit counters); no saturation logic, wrap is explicit.
//  - The stage has no handshake; downstream samples x/y/video_on when pixel_tick=1.
// CONFIGURATION
//  VGA_SYNC_ALIGN_EN defined: hsync, vsync and video_on pass through one extra register stage enabled by
//   pixel_tick (1-pixel delay), to match a registered colour stage downstream. Delayed copies reset to
//   inactive/0. x, y and the strobes are undelayed.
//  Not defined: sync/video_on change in the same cycle as x/y (zero added latency).
// TESTING
//  1. Hold reset 5 clks -> x=0,y=0,hsync=vsync=1,video_on=0,pulses 0; release -> video_on=1 next clk.
//  2. Free-run CLK_DIV=2 -> line_start period 1600 clks; x sequence 0..799 then 0; y increments once/line.
//  3. Single line -> hsync low exactly 96 ticks, first low with x=656, high again at x=752.
//  4. Full frame -> frame_start period 840000 clks; vsync low for lines 490-491 (1600 ticks);
//     video_on high for 307200 ticks.
//  5. Assert reset at x=300,y=200 for 1 clk -> next clk reset values; raster restarts, frame_start after
//     a full 840000 clks.
//  6. VGA_SYNC_ALIGN_EN defined -> hsync falls one pixel_tick after x=656; video_on falls at x=641;
//     x/y timing unchanged versus test 3.

Source files
------------

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480@60 VGA raster timing with pixel-rate enable, counters, syncs and strobes.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/video_on by one pixel for a registered colour stage.
module vga_scan_timing #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SA       = SYNC_ACTIVE != 0;
  logic [DW-1:0] div, div_n;
  logic [9:0] x_n, y_n, sx, sy;
  logic tick, tick_n, wrap_n, en;
  always_comb begin
    tick   = div == DIV_LAST;
    div_n  = tick ? '0 : div + 1'b1;
    x_n    = !tick ? x : (x == H_LAST) ? '0 : x + 10'd1;
    y_n    = !(tick && x == H_LAST) ? y : (y == V_LAST) ? '0 : y + 10'd1;
    tick_n = div_n == DIV_LAST;
    wrap_n = tick_n && x_n == H_LAST;
  end
  // Aligned build decodes the pixel just left, so the syncs trail x/y by one pixel.
`ifdef VGA_SYNC_ALIGN_EN
  assign {sx, sy, en} = {x, y, tick};
`else
  assign {sx, sy, en} = {x_n, y_n, 1'b1};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_n;
      x           <= x_n;
      y           <= y_n;
      pixel_tick  <= tick_n;
      line_start  <= wrap_n;
      frame_start <= wrap_n && y_n == V_LAST;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync    <= ~SA;
      vsync    <= ~SA;
      video_on <= 1'b0;
    end else if (en) begin
      hsync    <= (sx >= HS_START && sx < HS_END) ? SA : ~SA;
      vsync    <= (sy >= VS_START && sy < VS_END) ? SA : ~SA;
      video_on <= sx < H_VIS && sy < V_VIS;
    end
  end
endmodule
